cam_stream_tx: RTL and testbench
================================

// Module: cam_stream_tx
// PURPOSE
//  Camera-side transmitter for the parallel capture path. Wishbone host pushes
//  32-bit words into a small FIFO. The block replays them as an 8-bit
//  PCLK/VSYNC/HREF/DATA stream that the FPGA capture RAM logic accepts as if
//  from a sensor. Used for loopback test and for driving external parallel sinks.
// PARAMETERS
//  FIFO_AW   4   log2 FIFO depth in 32-bit words (depth 16)
//  CLK_DIV   2   WBs_CLK_i cycles per PCLKO half-period (>=1)
//  H_BLANK   8   PCLK cycles HREFO low between lines
//  V_BLANK   16  PCLK cycles VSYNCO high, HREFO low, before first and after last line
// PORTS
//  WBs_CLK_i       in   1   system/Wishbone clock, sole clock
//  WBs_RST_i       in   1   asynchronous reset, active high
//  WBs_ADR_i       in   2   word register select: 0 CTRL, 1 STATUS, 2 DATA, 3 LINE_CFG
//  WBs_CYC_i       in   1   cycle select for this block
//  WBs_STB_i       in   1   strobe
//  WBs_WE_i        in   1   write enable
//  WBs_BYTE_STB_i  in   4   byte enables (CTRL/LINE_CFG only; DATA always full word)
//  WBs_DAT_i       in   32  write data
//  WBs_DAT_o       out  32  read data, combinational from WBs_ADR_i, valid while WBs_ACK_o
//  WBs_ACK_o       out  1   acknowledge
//  PCLKO           out  1   pixel clock out
//  VSYNCO          out  1   frame valid, active high
//  HREFO           out  1   line/byte valid, active high
//  DATO            out  8   pixel byte
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; stickies 0; FSM IDLE; LINE_CFG 0.
//  ACK: ack_nxt = CYC & STB & ~ACK; registered, one-cycle pulse, 1 wait state.
//    Register side effects fire only on the cycle with ack_nxt=1.
//  CTRL (W): b0 START (self-clearing), b1 ABORT (self-clearing), b2 FIFO_FLUSH.
//    Reads return 0.
//  LINE_CFG (RW): [8:0] words/line, 0 means 512; [25:16] lines/frame, 0 means 1024.
//  DATA (W): push WBs_DAT_i. Push when full is dropped and sets OVF. Reads return 0.
//  STATUS (R): b0 BUSY (FSM!=IDLE), b1 FULL, b2 EMPTY, b3 OVF, b4 STALL,
//    [8+FIFO_AW:8] level. A write with DAT[3]/[4]=1 clears that sticky.
//  PCLKO free-runs from reset: toggles every CLK_DIV clocks (period 2*CLK_DIV).
//    VSYNCO, HREFO and DATO change only on the clock where PCLKO goes 1->0.
//    Receiver samples on the rising edge.
//  Byte order: word[31:24] first, then [23:16], [15:8], [7:0].
//  FSM (advances on falling-edge ticks):
//    IDLE  -> VPRE on START. START while BUSY is ignored.
//    VPRE  VSYNCO=1 HREFO=0 for V_BLANK ticks -> LINE.
//    LINE  HREFO=1. Emits words/line*4 bytes. Pops FIFO on the tick emitting byte 0.
//      If FIFO empty at a pop point: HREFO=0, DATO held, STALL set, wait.
//      Resume on first tick with data present.
//      Last byte of line -> HBLANK, or VPOST if this was the last line.
//    HBLANK  HREFO=0 for H_BLANK ticks -> LINE.
//    VPOST  VSYNCO=1 for V_BLANK ticks -> IDLE (VSYNCO=0).
//  ABORT: on next tick FSM->IDLE, VSYNCO/HREFO=0. Partly sent word discarded.
//    FIFO kept.
//  FIFO_FLUSH: level->0 same cycle. If simultaneous with push, flush wins.
//  Push and pop in same cycle: both occur, level unchanged. Push when full and
//    pop in same cycle: push accepted.
//  Counters: byte idx 2b, word/line 10b, line 11b, blank/div counters sized by
//    $clog2 of params. All wrap-free (reloaded per state).
//  Async reset mid-frame: outputs drop to 0 immediately. LINE_CFG lost.
// STRUCTURE
//  cam_stream_tx_defs.vh: register offsets, CTRL/STATUS bit positions, FSM
//    state encodings (IDLE/VPRE/LINE/HBLANK/VPOST).
//  Sub-module cam_tx_fifo: single-clock FIFO, FIFO_AW param, push/pop/flush,
//    full/empty/level, first-word-fall-through.
//  Top: WB decode/ACK, CTRL/STATUS regs, PCLK divider, frame FSM, byte mux.
// TESTING
//  1 Reset, read STATUS -> 0x00000004 (EMPTY). PCLKO period 4 clk (CLK_DIV=2).
//    VSYNCO/HREFO=0.
//  2 LINE_CFG=0x0002_0002, push 0x11223344,0x55667788,0x99AABBCC,0xDDEEFF00,
//    START. Capture 16 bytes in 2 HREF bursts of 8: 11..88, 99..00.
//    VSYNC spans both. BUSY clears after VPOST.
//  3 Push 17 words with depth 16 -> 17th dropped, STATUS OVF=1, level=16.
//    Write STATUS b3=1 -> OVF=0.
//  4 LINE_CFG 1 line/2 words, push 1 word, START -> HREFO low after 4 bytes,
//    STALL=1. Push 2nd word -> HREFO resumes with its MSB.
//  5 ABORT mid-line -> next falling tick VSYNCO=HREFO=0, BUSY=0,
//    FIFO level unchanged.
//  6 Loopback into capture path (VSYNC&HREF valid, posedge sample):
//    bytes received equal bytes pushed. Async reset mid-LINE clears all outputs
//    same cycle.

Source files
------------

// File: rtl/cam_stream_tx_pkg.sv
// Shared definitions for the camera stream transmitter: register map,
// CTRL/STATUS bit positions, frame FSM encodings and the byte lane mux.
package cam_stream_tx_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_DATA     = 2'd2;
  localparam logic [1:0] REG_LINE_CFG = 2'd3;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_ABORT = 1;
  localparam int unsigned CTRL_FLUSH = 2;

  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_STALL     = 4;
  localparam int unsigned ST_LEVEL_LSB = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VPRE   = 3'd1;
  localparam logic [2:0] S_LINE   = 3'd2;
  localparam logic [2:0] S_HBLANK = 3'd3;
  localparam logic [2:0] S_VPOST  = 3'd4;

  // Most significant byte goes out first.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/cam_tx_fifo.sv
// Single-clock first-word-fall-through FIFO of 32-bit words with flush.
module cam_tx_fifo #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [31:0]        din,
  output logic [31:0]        dout,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

  logic [31:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];
  assign pop_ok  = pop & ~empty & ~flush;
  // A pop in the same cycle frees a slot, so a push against a full FIFO still lands.
  assign push_ok = push & ~flush & (~full | pop_ok);

  // Storage write.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointer and level bookkeeping; flush empties immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/cam_stream_tx.sv
// Camera-side parallel stream transmitter: Wishbone-fed word FIFO replayed
// as a PCLK/VSYNC/HREF/DATA byte stream.
module cam_stream_tx
  import cam_stream_tx_pkg::*;
#(
  parameter int unsigned FIFO_AW = 4,
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned H_BLANK = 8,
  parameter int unsigned V_BLANK = 16
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic [1:0]  WBs_ADR_i,
  input  logic        WBs_CYC_i,
  input  logic        WBs_STB_i,
  input  logic        WBs_WE_i,
  input  logic [3:0]  WBs_BYTE_STB_i,
  input  logic [31:0] WBs_DAT_i,
  output logic [31:0] WBs_DAT_o,
  output logic        WBs_ACK_o,
  output logic        PCLKO,
  output logic        VSYNCO,
  output logic        HREFO,
  output logic [7:0]  DATO
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned MAXB  = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int unsigned BLK_W = $clog2(MAXB + 1);

  logic               ack_nxt, wr;
  logic               ctrl_wr, start_wr, abort_wr, flush;
  logic               data_wr, status_wr, cfg_wr;
  logic               start_pend, abort_pend;
  logic               ovf, stall;
  logic [8:0]         cfg_words;
  logic [9:0]         cfg_lines;
  logic [9:0]         words_m1;
  logic [10:0]        lines_m1;
  logic [DIV_W-1:0]   div_cnt;
  logic               div_last, tick;
  logic [2:0]         state;
  logic [BLK_W-1:0]   cnt;
  logic [1:0]         byte_idx;
  logic [9:0]         word_cnt;
  logic [10:0]        line_cnt;
  logic [31:0]        word_reg;
  logic               emit, fetch, pop, stall_set;
  logic [31:0]        fifo_dout;
  logic               fifo_full, fifo_empty;
  logic [FIFO_AW:0]   fifo_level;

  assign ack_nxt   = WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o;
  assign wr        = ack_nxt & WBs_WE_i;
  assign ctrl_wr   = wr & (WBs_ADR_i == REG_CTRL) & WBs_BYTE_STB_i[0];
  assign start_wr  = ctrl_wr & WBs_DAT_i[CTRL_START];
  assign abort_wr  = ctrl_wr & WBs_DAT_i[CTRL_ABORT];
  assign flush     = ctrl_wr & WBs_DAT_i[CTRL_FLUSH];
  assign data_wr   = wr & (WBs_ADR_i == REG_DATA);
  assign status_wr = wr & (WBs_ADR_i == REG_STATUS);
  assign cfg_wr    = wr & (WBs_ADR_i == REG_LINE_CFG);

  assign words_m1 = (cfg_words == '0) ? 10'd511  : ({1'b0, cfg_words} - 10'd1);
  assign lines_m1 = (cfg_lines == '0) ? 11'd1023 : ({1'b0, cfg_lines} - 11'd1);

  assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign tick     = div_last & PCLKO;

  // Entering a line happens on the tick that ends a blanking count, so the
  // first byte goes out on that same tick and blanking lasts exactly its length.
  assign emit      = tick & ~abort_pend &
                     ((state == S_LINE) ||
                      (((state == S_VPRE) || (state == S_HBLANK)) && (cnt == '0)));
  assign fetch     = emit & (byte_idx == 2'd0);
  assign pop       = fetch & ~fifo_empty;
  assign stall_set = fetch & fifo_empty;

  cam_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (WBs_CLK_i),
    .rst   (WBs_RST_i),
    .push  (data_wr),
    .pop   (pop),
    .flush (flush),
    .din   (WBs_DAT_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Single wait-state acknowledge.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) WBs_ACK_o <= 1'b0;
    else           WBs_ACK_o <= ack_nxt;
  end

  // LINE_CFG register with byte enables.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      cfg_words <= '0;
      cfg_lines <= '0;
    end else if (cfg_wr) begin
      if (WBs_BYTE_STB_i[0]) cfg_words[7:0] <= WBs_DAT_i[7:0];
      if (WBs_BYTE_STB_i[1]) cfg_words[8]   <= WBs_DAT_i[8];
      if (WBs_BYTE_STB_i[2]) cfg_lines[7:0] <= WBs_DAT_i[23:16];
      if (WBs_BYTE_STB_i[3]) cfg_lines[9:8] <= WBs_DAT_i[25:24];
    end
  end

  // Sticky status flags; a new event wins over a simultaneous clear.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      ovf   <= 1'b0;
      stall <= 1'b0;
    end else begin
      if (data_wr && fifo_full && !pop && !flush) ovf <= 1'b1;
      else if (status_wr && WBs_DAT_i[ST_OVF])      ovf <= 1'b0;
      if (stall_set)                                stall <= 1'b1;
      else if (status_wr && WBs_DAT_i[ST_STALL])    stall <= 1'b0;
    end
  end

  // START/ABORT requests are held until the next falling PCLK tick.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      start_pend <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      if (start_wr && state == S_IDLE) start_pend <= 1'b1;
      else if (tick)                   start_pend <= 1'b0;
      if (abort_wr)                    abort_pend <= 1'b1;
      else if (tick)                   abort_pend <= 1'b0;
    end
  end

  // Free-running PCLK divider.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      div_cnt <= '0;
      PCLKO   <= 1'b0;
    end else if (div_last) begin
      div_cnt <= '0;
      PCLKO   <= ~PCLKO;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame FSM and output stream, advancing only on falling PCLK ticks.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      byte_idx <= '0;
      word_cnt <= '0;
      line_cnt <= '0;
      word_reg <= '0;
      VSYNCO   <= 1'b0;
      HREFO    <= 1'b0;
      DATO     <= '0;
    end else if (tick) begin
      if (abort_pend) begin
        state    <= S_IDLE;
        VSYNCO   <= 1'b0;
        HREFO    <= 1'b0;
        byte_idx <= '0;
      end else if (emit) begin
        state  <= S_LINE;
        VSYNCO <= 1'b1;
        if (byte_idx == 2'd0) begin
          if (fifo_empty) begin
            HREFO <= 1'b0;
          end else begin
            word_reg <= fifo_dout;
            DATO     <= fifo_dout[31:24];
            HREFO    <= 1'b1;
            byte_idx <= 2'd1;
          end
        end else begin
          DATO     <= byte_sel(word_reg, byte_idx);
          HREFO    <= 1'b1;
          byte_idx <= byte_idx + 1'b1;
          if (byte_idx == 2'd3) begin
            if (word_cnt == words_m1) begin
              word_cnt <= '0;
              if (line_cnt == lines_m1) begin
                state    <= S_VPOST;
                cnt      <= BLK_W'(V_BLANK);
                line_cnt <= '0;
              end else begin
                state    <= S_HBLANK;
                cnt      <= BLK_W'(H_BLANK);
                line_cnt <= line_cnt + 11'd1;
              end
            end else begin
              word_cnt <= word_cnt + 10'd1;
            end
          end
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start_pend) begin
              state    <= S_VPRE;
              VSYNCO   <= 1'b1;
              HREFO    <= 1'b0;
              cnt      <= BLK_W'(V_BLANK - 1);
              byte_idx <= '0;
              word_cnt <= '0;
              line_cnt <= '0;
            end
          end
          S_VPRE, S_HBLANK: begin
            HREFO <= 1'b0;
            cnt   <= cnt - 1'b1;
          end
          S_VPOST: begin
            HREFO <= 1'b0;
            if (cnt == '0) begin
              state  <= S_IDLE;
              VSYNCO <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Register read mux.
  always_comb begin
    WBs_DAT_o = '0;
    case (WBs_ADR_i)
      REG_STATUS: begin
        WBs_DAT_o[ST_BUSY]  = (state != S_IDLE);
        WBs_DAT_o[ST_FULL]  = fifo_full;
        WBs_DAT_o[ST_EMPTY] = fifo_empty;
        WBs_DAT_o[ST_OVF]   = ovf;
        WBs_DAT_o[ST_STALL] = stall;
        WBs_DAT_o[ST_LEVEL_LSB +: FIFO_AW + 1] = fifo_level;
      end
      REG_LINE_CFG: begin
        WBs_DAT_o[8:0]   = cfg_words;
        WBs_DAT_o[25:16] = cfg_lines;
      end
      default: WBs_DAT_o = '0;
    endcase
  end

endmodule

// File: tb/tb_cam_stream_tx.sv
// Bench for cam_stream_tx: Wishbone register tests plus a byte-stream
// receiver that checks every captured byte against the pushed word order.
module tb_cam_stream_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  adr = '0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  bs = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ack, pclk, vs, hr;
  logic [7:0]  dat;

  always #5 clk = ~clk;

  cam_stream_tx #(.FIFO_AW(4), .CLK_DIV(2), .H_BLANK(8), .V_BLANK(16)) dut (
    .WBs_CLK_i      (clk),
    .WBs_RST_i      (rst),
    .WBs_ADR_i      (adr),
    .WBs_CYC_i      (cyc),
    .WBs_STB_i      (stb),
    .WBs_WE_i       (we),
    .WBs_BYTE_STB_i (bs),
    .WBs_DAT_i      (dat_i),
    .WBs_DAT_o      (dat_o),
    .WBs_ACK_o      (ack),
    .PCLKO          (pclk),
    .VSYNCO         (vs),
    .HREFO          (hr),
    .DATO           (dat)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int         gaps[$];
  int         bursts[$];
  logic       mon_en = 1'b0;
  logic       p_pclk = 1'b0, p_vs = 1'b0, p_hr = 1'b0;
  logic [7:0] p_dat = '0;
  logic [7:0] exp_b;
  int         run = 0, low_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Receiver model: sample on rising PCLK while VSYNC&HREF, bytes must match
  // pushed words MSB first; outputs may only move when PCLK falls.
  always @(negedge clk) begin
    if (mon_en) begin
      if ({vs, hr, dat} !== {p_vs, p_hr, p_dat})
        check("edge_align", {31'b0, p_pclk & ~pclk}, 32'd1);
      if (hr) check("href_in_vsync", {31'b0, vs}, 32'd1);
      if (!p_pclk && pclk) begin
        if (vs && hr) begin
          rx_log.push_back(dat);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rx_byte: got %h want <none>", dat);
          end else begin
            exp_b = exp_q.pop_front();
            check("rx_byte", {24'b0, dat}, {24'b0, exp_b});
          end
          run++;
          if (low_run > 0) begin gaps.push_back(low_run); low_run = 0; end
        end else begin
          if (run > 0) begin bursts.push_back(run); run = 0; end
          if (vs) low_run++;
          else if (low_run > 0) begin gaps.push_back(low_run); low_run = 0; end
        end
      end
    end
    p_pclk = pclk; p_vs = vs; p_hr = hr; p_dat = dat;
  end

  task automatic wb_xfer(input logic [1:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] r);
    int n;
    @(negedge clk);
    adr = a; we = w; dat_i = d; bs = be; cyc = 1'b1; stb = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 8);
    if (!ack) begin total++; bad++; $display("FAIL wb_ack: got 0 want 1"); end
    r = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(a, 1'b1, d, 4'hF, r);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] r);
    wb_xfer(a, 1'b0, 32'h0, 4'hF, r);
  endtask

  task automatic push_word(input logic [31:0] w);
    wb_write(2'd2, w);
    exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
  endtask

  task automatic wait_status_bit(input string name, input int bitpos, input logic val, input int limit);
    logic [31:0] st;
    int n;
    n = 0;
    do begin wb_read(2'd1, st); n++; end while (st[bitpos] !== val && n < limit);
    check(name, {31'b0, st[bitpos]}, {31'b0, val});
  endtask

  task automatic clear_mon();
    rx_log.delete(); gaps.delete(); bursts.delete();
    run = 0; low_run = 0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    longint t0, t1;
    int n, k;

    // 1: reset state
    repeat (3) @(negedge clk);
    check("rst_outputs", {21'b0, ack, pclk, vs, hr, dat}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    wb_read(2'd1, r);  check("rst_status", r, 32'h0000_0004);
    wb_read(2'd3, r);  check("rst_line_cfg", r, 32'h0);
    wb_read(2'd0, r);  check("ctrl_read_zero", r, 32'h0);
    n = 0;
    while (!(p_pclk == 1'b0 && pclk == 1'b1) && n < 20) begin @(negedge clk); n++; end
    t0 = $time;
    @(negedge clk); n = 0;
    while (!(p_pclk == 1'b0 && pclk == 1'b1) && n < 20) begin @(negedge clk); n++; end
    t1 = $time;
    check("pclk_period", 32'(t1 - t0), 32'd40);
    check("idle_sync", {30'b0, vs, hr}, 32'h0);

    // 2: two lines of two words
    wb_write(2'd3, 32'h0002_0002);
    wb_read(2'd3, r);  check("line_cfg_rb", r, 32'h0002_0002);
    clear_mon();
    push_word(32'h1122_3344); push_word(32'h5566_7788);
    push_word(32'h99AA_BBCC); push_word(32'hDDEE_FF00);
    wb_write(2'd0, 32'h1);
    wait_status_bit("busy_set", 0, 1'b1, 40);
    wait_status_bit("busy_clear", 0, 1'b0, 400);
    repeat (8) @(negedge clk);
    check("f2_nbytes", rx_log.size(), 32'd16);
    check("f2_byte0", {24'b0, rx_log[0]},  32'h11);
    check("f2_byte7", {24'b0, rx_log[7]},  32'h88);
    check("f2_byte8", {24'b0, rx_log[8]},  32'h99);
    check("f2_byte15", {24'b0, rx_log[15]}, 32'h00);
    check("f2_bursts", bursts.size(), 32'd2);
    check("f2_burst0", bursts[0], 32'd8);
    check("f2_burst1", bursts[1], 32'd8);
    check("f2_ngaps", gaps.size(), 32'd3);
    check("f2_vpre", gaps[0], 32'd16);
    check("f2_hblank", gaps[1], 32'd8);
    check("f2_vpost", gaps[2], 32'd16);
    check("f2_model_empty", exp_q.size(), 32'd0);

    // 3: overflow on the 17th word
    for (int i = 0; i < 16; i++) push_word(32'hA000_0000 + i);
    wb_write(2'd2, 32'hDEAD_BEEF);
    wb_read(2'd1, r);  check("ovf_status", r, 32'h0000_100A);
    wb_write(2'd1, 32'h8);
    wb_read(2'd1, r);  check("ovf_cleared", r, 32'h0000_1002);
    wb_write(2'd0, 32'h4);
    exp_q.delete();
    wb_read(2'd1, r);  check("flush_status", r, 32'h0000_0004);

    // 4: underrun stall then resume
    wb_write(2'd3, 32'h0001_0002);
    clear_mon();
    push_word(32'hA1B2_C3D4);
    wb_write(2'd0, 32'h1);
    wait_status_bit("stall_set", 4, 1'b1, 400);
    check("stall_nbytes", rx_log.size(), 32'd4);
    check("stall_href_low", {31'b0, hr}, 32'd0);
    push_word(32'hE5F6_0718);
    wait_status_bit("stall_done", 0, 1'b0, 400);
    repeat (8) @(negedge clk);
    check("resume_msb", {24'b0, rx_log[4]}, 32'hE5);
    check("stall_bursts", bursts.size(), 32'd2);
    check("stall_burst1", bursts[1], 32'd4);
    wb_write(2'd1, 32'h10);
    wb_read(2'd1, r);  check("stall_cleared", r, 32'h0000_0004);

    // 5: abort mid-line
    wb_write(2'd3, 32'h0001_0004);
    clear_mon();
    push_word(32'h0102_0304); push_word(32'h0506_0708);
    push_word(32'h090A_0B0C); push_word(32'h0D0E_0F10);
    wb_write(2'd0, 32'h1);
    n = 0;
    while (rx_log.size() < 6 && n < 400) begin @(negedge clk); n++; end
    check("abort_reach", {31'b0, rx_log.size() >= 6}, 32'd1);
    wb_write(2'd0, 32'h2);
    n = 0;
    while (vs && n < 8) begin @(negedge clk); n++; end
    check("abort_sync", {30'b0, vs, hr}, 32'h0);
    wb_read(2'd1, r);  check("abort_status", r, 32'h0000_0200);
    k = (4 - (rx_log.size() % 4)) % 4;
    repeat (k) void'(exp_q.pop_front());
    check("abort_model_left", exp_q.size(), 32'd8);

    // 6: loopback of the remaining words, then async reset mid-line
    wb_write(2'd3, 32'h0001_0002);
    repeat (4) @(negedge clk);
    clear_mon();
    wb_write(2'd0, 32'h1);
    wait_status_bit("loop_busy", 0, 1'b1, 40);
    wait_status_bit("loop_done", 0, 1'b0, 400);
    repeat (8) @(negedge clk);
    check("loop_nbytes", rx_log.size(), 32'd8);
    check("loop_first", {24'b0, rx_log[0]}, 32'h09);
    check("loop_model_empty", exp_q.size(), 32'd0);

    wb_write(2'd3, 32'h0001_0004);
    clear_mon();
    push_word(32'hC0FF_EE11); push_word(32'h2233_4455);
    push_word(32'h6677_8899); push_word(32'hAABB_CCDD);
    wb_write(2'd0, 32'h1);
    n = 0;
    while (rx_log.size() < 3 && n < 400) begin @(negedge clk); n++; end
    check("rst_href_before", {31'b0, hr}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    mon_en = 1'b0;
    #1;
    check("async_rst_out", {22'b0, pclk, vs, hr, dat}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    clear_mon();
    @(negedge clk);
    mon_en = 1'b1;
    wb_read(2'd1, r);  check("post_rst_status", r, 32'h0000_0004);
    wb_read(2'd3, r);  check("post_rst_cfg", r, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
